// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: conversion frame scheduler for a dual 12-bit serial ADC.
// Produces frames periodically (or on trigger), drives the shared chip select and
// serial clock from flops, deserialises both channels and holds the sample pair
// in a valid/ready output register with sticky missed-tick and overrun flags.
// Optional feature macro: ADC_SCHED_TRIG_EN (when defined, trig starts a frame).
module adc_frame_scheduler #(
  parameter int SCLK_DIV   = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int PERIOD_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 trig,
  input  logic                 clr_flags,
  input  logic                 a_sdi,
  input  logic                 b_sdi,
  output logic                 adc_sclk,
  output logic                 adc_cs_n,
  output logic [DATA_BITS-1:0] a_data,
  output logic [DATA_BITS-1:0] b_data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 missed_tick,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(2 * SCLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_QUIET
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [PERIOD_W-1:0]   timer_q, timer_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic [FRAME_BITS-1:0] shift_a_q, shift_a_d;
  logic [FRAME_BITS-1:0] shift_b_q, shift_b_d;
  logic [DATA_BITS-1:0]  a_data_q, a_data_d;
  logic [DATA_BITS-1:0]  b_data_q, b_data_d;
  logic                  valid_q, valid_d;
  logic                  missed_q, missed_d;
  logic                  overrun_q, overrun_d;

  logic [PERIOD_W-1:0]   period_eff;
  logic                  tick;
  logic                  trig_start;
  logic                  start;
  logic                  load;

`ifdef ADC_SCHED_TRIG_EN
  assign trig_start = trig;
`else
  // trig is kept on the port list for pin compatibility but has no effect
  logic unused_trig;
  assign unused_trig = trig;
  assign trig_start  = 1'b0;
`endif

  // The top bits of the frame shift registers hold header bits that are never presented
  logic unused_shift_msbs;
  assign unused_shift_msbs = ^{shift_a_q[FRAME_BITS-1:DATA_BITS], shift_b_q[FRAME_BITS-1:DATA_BITS]};

  // Frame-rate timer: free-running while enabled, a period of 0 behaves as 1
  always_comb begin
    period_eff = (period == '0) ? PERIOD_W'(1) : period;
    tick       = en && (timer_q == (period_eff - PERIOD_W'(1)));
    if (!en || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + PERIOD_W'(1);
    end
    start = (state_q == S_IDLE) && (tick || trig_start);
  end

  // Frame sequencer: chip select and SCLK waveform plus MSB-first capture on SCLK rise
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            shift_a_d = {shift_a_q[FRAME_BITS-2:0], a_sdi};
            shift_b_d = {shift_b_q[FRAME_BITS-2:0], b_sdi};
          end else if (bit_q == BIT_LAST) begin
            state_d = S_QUIET;
            cs_n_d  = 1'b1;
            load    = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // Output pair register and sticky flags; a set event wins over clr_flags
  always_comb begin
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q && !clr_flags;
    missed_d  = missed_q && !clr_flags;
    if (tick && (state_q != S_IDLE)) begin
      missed_d = 1'b1;
    end
    if (load) begin
      a_data_d = shift_a_q[DATA_BITS-1:0];
      b_data_d = shift_b_q[DATA_BITS-1:0];
      valid_d  = 1'b1;
      if (valid_q && !data_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output flops with synchronous reset; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      timer_q   <= '0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      shift_a_q <= '0;
      shift_b_q <= '0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      valid_q   <= 1'b0;
      missed_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      timer_q   <= timer_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      valid_q   <= valid_d;
      missed_q  <= missed_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_sclk    = sclk_q;
  assign adc_cs_n    = cs_n_q;
  assign a_data      = a_data_q;
  assign b_data      = b_data_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign missed_tick = missed_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Testbench for adc_frame_scheduler: a frame-age based reference model predicts every
// output each cycle, an ADC model drives the serial lines, and a few literal checks pin
// the model (latencies, edge counts, captured words, flag behaviour).
module tb_adc_frame_scheduler;

  localparam int D  = 2;
  localparam int F  = 16;
  localparam int DB = 12;
  localparam int PW = 16;
  localparam int FRAME_LEN   = D * (2 * F + 3);
  localparam int CS_LAST_AGE = D + 2 * F * D;
  localparam int LOAD_AGE    = 1 + D + 2 * F * D;
`ifdef ADC_SCHED_TRIG_EN
  localparam bit TRIG_ON = 1'b1;
`else
  localparam bit TRIG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] period = 16'd100;
  logic          trig = 1'b0;
  logic          clr_flags = 1'b0;
  logic          a_sdi = 1'b0;
  logic          b_sdi = 1'b0;
  logic          data_ready = 1'b1;
  logic          adc_sclk, adc_cs_n, data_valid, busy, missed_tick, overrun;
  logic [DB-1:0] a_data, b_data;

  adc_frame_scheduler #(
    .SCLK_DIV(D), .FRAME_BITS(F), .DATA_BITS(DB), .PERIOD_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .trig(trig),
    .clr_flags(clr_flags), .a_sdi(a_sdi), .b_sdi(b_sdi),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .a_data(a_data), .b_data(b_data),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .missed_tick(missed_tick), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  logic [PW-1:0] m_timer = '0;
  bit            m_in_frame = 1'b0;
  int            m_age = 0;
  bit            fixed_mode = 1'b1;
  logic [15:0]   frame_a = 16'h0ABC;
  logic [15:0]   frame_b = 16'h0123;
  bit            e_cs_n = 1'b1, e_sclk = 1'b1, e_busy = 1'b0, e_valid = 1'b0;
  bit            e_missed = 1'b0, e_overrun = 1'b0;
  logic [DB-1:0] e_a = '0, e_b = '0;

  // monitor state for literal checks
  bit            prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  int            frames_seen = 0, last_cs_fall = -1000, frame_interval = 0;
  int            rises = 0, last_window_rises = 0, valid_lat = 0;
  logic [DB-1:0] cap_a = '0, cap_b = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // One clock of the reference: frame occupancy tracked as an age since the start tick
  task automatic modelStep();
    logic [PW-1:0] pe;
    bit tick, start, busy_before, load, ov_set;
    cyc++;
    if (rst) begin
      m_timer = '0; m_in_frame = 1'b0; m_age = 0;
      e_valid = 1'b0; e_missed = 1'b0; e_overrun = 1'b0; e_a = '0; e_b = '0;
    end else begin
      pe = (period == '0) ? 16'd1 : period;
      tick = en && (m_timer == pe - 16'd1);
      m_timer = (!en || tick) ? 16'd0 : m_timer + 16'd1;
      busy_before = m_in_frame;
      start = !busy_before && (tick || (TRIG_ON && trig));
      load = 1'b0;
      ov_set = 1'b0;
      if (m_in_frame) begin
        m_age++;
        if (m_age > FRAME_LEN) m_in_frame = 1'b0;
        else if (m_age == LOAD_AGE) load = 1'b1;
      end
      if (start) begin
        m_in_frame = 1'b1;
        m_age = 1;
        if (fixed_mode) begin
          frame_a = 16'h0ABC; frame_b = 16'h0123;
        end else begin
          frame_a = 16'($urandom); frame_b = 16'($urandom);
        end
      end
      if (load) begin
        if (e_valid && !data_ready) ov_set = 1'b1;
        e_valid = 1'b1; e_a = frame_a[DB-1:0]; e_b = frame_b[DB-1:0];
      end else if (e_valid && data_ready) begin
        e_valid = 1'b0;
      end
      e_missed  = (tick && busy_before) ? 1'b1 : (clr_flags ? 1'b0 : e_missed);
      e_overrun = ov_set ? 1'b1 : (clr_flags ? 1'b0 : e_overrun);
    end
    e_busy = m_in_frame;
    e_cs_n = !(m_in_frame && m_age <= CS_LAST_AGE);
    e_sclk = !m_in_frame || m_age <= D || m_age > CS_LAST_AGE || (((m_age - 1 - D) / D) % 2 == 1);
  endtask

  // Per-cycle compare against the model, then edge bookkeeping for literal checks
  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput("adc_cs_n", 32'(adc_cs_n), 32'(e_cs_n));
    checkOutput("adc_sclk", 32'(adc_sclk), 32'(e_sclk));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("data_valid", 32'(data_valid), 32'(e_valid));
    checkOutput("a_data", 32'(a_data), 32'(e_a));
    checkOutput("b_data", 32'(b_data), 32'(e_b));
    checkOutput("missed_tick", 32'(missed_tick), 32'(e_missed));
    checkOutput("overrun", 32'(overrun), 32'(e_overrun));
    if (prev_cs && !adc_cs_n) begin
      frames_seen++;
      frame_interval = cyc - last_cs_fall;
      last_cs_fall = cyc;
      rises = 0;
    end
    if (!adc_cs_n && !prev_sclk && adc_sclk) rises++;
    if (!prev_cs && adc_cs_n) last_window_rises = rises;
    if (!prev_valid && data_valid) begin
      valid_lat = cyc - last_cs_fall;
      cap_a = a_data;
      cap_b = b_data;
    end
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
    prev_valid = data_valid;
  end

  // ADC model: presents the next frame bit MSB first after every SCLK fall
  int  bit_idx = 0;
  bit  sclk_seen = 1'b1;
  always @(negedge clk) begin
    if (adc_cs_n) begin
      bit_idx = 0;
      a_sdi = 1'($urandom);
      b_sdi = 1'($urandom);
    end else if (sclk_seen && !adc_sclk && bit_idx < 16) begin
      a_sdi = frame_a[15 - bit_idx];
      b_sdi = frame_b[15 - bit_idx];
      bit_idx++;
    end
    sclk_seen = adc_sclk;
  end

  task automatic applyStimulus();
    data_ready = ($urandom % 3) != 0;
    trig       = ($urandom % 40) == 0;
    clr_flags  = ($urandom % 50) == 0;
    rst        = ($urandom % 700) == 0;
    @(negedge clk);
  endtask

  task automatic pulseClear();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  initial begin
    int base;
    int waited;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", 32'(adc_cs_n), 1);
    checkOutput("reset_sclk", 32'(adc_sclk), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_valid", 32'(data_valid), 0);
    checkOutput("reset_a_data", 32'(a_data), 0);
    checkOutput("reset_flags", 32'({missed_tick, overrun}), 0);
    rst = 1'b0;

    // nominal periodic capture with fixed ADC words
    base = frames_seen;
    period = 16'd100; en = 1'b1;
    repeat (320) @(negedge clk);
    checkOutput("frames_in_320", 32'(frames_seen - base), 3);
    checkOutput("frame_interval", 32'(frame_interval), 100);
    checkOutput("valid_latency", 32'(valid_lat), 66);
    checkOutput("sclk_rises", 32'(last_window_rises), 16);
    checkOutput("cap_a", 32'(cap_a), 32'h0ABC);
    checkOutput("cap_b", 32'(cap_b), 32'h0123);
    en = 1'b0;
    repeat (80) @(negedge clk);

    // minimum period back-to-back, then one cycle too short
    fixed_mode = 1'b0;
    base = frames_seen;
    period = 16'd71; en = 1'b1;
    repeat (400) @(negedge clk);
    en = 1'b0;
    repeat (80) @(negedge clk);
    checkOutput("frames_at_71", 32'(frames_seen - base), 5);
    checkOutput("missed_at_71", 32'(missed_tick), 0);
    period = 16'd70; en = 1'b1;
    repeat (160) @(negedge clk);
    checkOutput("missed_at_70", 32'(missed_tick), 1);
    en = 1'b0;
    repeat (80) @(negedge clk);
    pulseClear();
    checkOutput("missed_cleared", 32'(missed_tick), 0);

    // consumer stalled across two frames
    data_ready = 1'b0; period = 16'd100; en = 1'b1;
    repeat (280) @(negedge clk);
    en = 1'b0;
    checkOutput("overrun_set", 32'(overrun), 1);
    checkOutput("valid_held", 32'(data_valid), 1);
    data_ready = 1'b1;
    @(negedge clk);
    checkOutput("valid_dropped", 32'(data_valid), 0);
    pulseClear();
    checkOutput("overrun_cleared", 32'(overrun), 0);
    repeat (20) @(negedge clk);

    // reset in the middle of a frame, then a clean capture
    fixed_mode = 1'b1; en = 1'b1;
    waited = 0;
    while (adc_cs_n && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("frame_started", 32'(adc_cs_n), 0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_cs_n", 32'(adc_cs_n), 1);
    checkOutput("abort_sclk", 32'(adc_sclk), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_valid", 32'(data_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    en = 1'b0;
    repeat (80) @(negedge clk);
    checkOutput("post_abort_lat", 32'(valid_lat), 66);
    checkOutput("post_abort_rises", 32'(last_window_rises), 16);
    checkOutput("post_abort_a", 32'(cap_a), 32'h0ABC);

    // single-shot trigger, second trigger lands while busy
    fixed_mode = 1'b0;
    base = frames_seen;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    repeat (10) @(negedge clk);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    repeat (90) @(negedge clk);
    checkOutput("trig_frames", 32'(frames_seen - base), TRIG_ON ? 1 : 0);
    checkOutput("trig_idle", 32'(busy), 0);
    checkOutput("trig_no_flag", 32'(missed_tick), 0);

    // period of zero ticks every cycle
    period = 16'd0; en = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("p0_busy", 32'(busy), 1);
    checkOutput("p0_missed", 32'(missed_tick), 1);
    en = 1'b0;
    repeat (80) @(negedge clk);
    pulseClear();

    // randomized segments checked by the model alone
    for (int seg = 0; seg < 10; seg++) begin
      en = 1'b0;
      @(negedge clk);
      period = ($urandom % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(60, 140));
      en = ($urandom % 4) != 0;
      repeat (300) applyStimulus();
    end
    rst = 1'b0; trig = 1'b0; clr_flags = 1'b0; en = 1'b0; data_ready = 1'b1;
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
